alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, default 32, operand/result width.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  2  per-requester request strobe; bit n = requester n.
REQ-005 Port: req_ready  out  2  per-requester accept; a request transfers when valid and ready are both high.
REQ-006 Port: req_a  in  2xW  per-requester operand A.
REQ-007 Port: req_b  in  2xW  per-requester operand B.
REQ-008 Port: req_alufn  in  2x6  per-requester 6-bit ALU function code.
REQ-009 Port: alu_a, alu_b  out  W each  operands driven to the shared ALU.
REQ-010 Port: alu_alufn  out  6  function code driven to the shared ALU.
REQ-011 Port: alu_otp  in  W, plus alu_zero and alu_overflow  in  1 each  results returned from the shared ALU.
REQ-012 Port: rsp_valid  out  1  response available.
REQ-013 Port: rsp_ready  in  1  consumer accepts the response.
REQ-014 Port: rsp_id  out  1  index of the requester that owns the response.
REQ-015 Port: rsp_otp  out  W, plus rsp_zero, rsp_overflow, rsp_err  out  1 each  registered result and flags.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-017 IDLE: req_ready SHALL be high only for the granted requester; a transfer captures a, b, alufn and id into registers, then the FSM moves to EXEC.
REQ-018 In every state other than IDLE, req_ready SHALL be 2'b00.
REQ-019 alu_a, alu_b and alu_alufn SHALL always be driven from the capture registers, never from req_* directly.
REQ-020 EXEC SHALL last exactly 1 cycle; at its end, alu_otp, alu_zero and alu_overflow SHALL be registered into the rsp_* outputs, and the FSM moves to RESP.
REQ-021 RESP: rsp_valid SHALL be high and all rsp_* outputs SHALL be held stable until rsp_ready is high; the FSM then returns to IDLE.
REQ-022 Latency: accept in cycle T gives rsp_valid in cycle T+2; minimum throughput is one operation per 3 cycles.
REQ-023 Legal alufn codes: 000000, 000001, 000010, 000100, 000101, 000110, 001000, 001001, 001011.
REQ-024 Any other alufn code SHALL be accepted, but respond with rsp_otp=0, rsp_zero=1, rsp_overflow=0, rsp_err=1.
REQ-025 For a legal code, rsp_err SHALL be 0.
REQ-026 When req_valid=2'b11 in IDLE, exactly one requester SHALL be granted, chosen per REQ-030/031.
REQ-027 A requester SHALL NOT be granted twice in a row while the other is continuously valid (REQ-030 builds only).
REQ-028 Dropping req_valid before a transfer SHALL cancel that request with no side effect.

Reset
REQ-029 When rst is high at a clock edge, the block SHALL: enter IDLE; clear rsp_valid, rsp_id, rsp_otp, rsp_zero, rsp_overflow, rsp_err and the capture registers (so alu_alufn=0); reset the priority pointer to requester 0. rst mid-EXEC or mid-RESP SHALL discard the operation with no response.

Configuration
REQ-030 With ALU_ARB_RR_EN defined, arbitration SHALL be round-robin: the requester granted last has lower priority at the next contention.
REQ-031 Without ALU_ARB_RR_EN, requester 0 SHALL always have fixed priority, and the priority pointer SHALL NOT exist.

Structure
REQ-032 The shared package alu_pkg SHALL hold the alufn code constants, the legal-code check function and the FSM state enum.
REQ-033 The grant logic SHALL be a single sub-module named alu_rr_grant (2-input arbiter with pointer).

Verification
REQ-034 Single op: req0 a=5, b=3, alufn=000000 -> rsp_valid at T+2 with otp=8, id=0, zero=0, err=0.
REQ-035 Contention: both requesters valid continuously, rsp_ready=1 -> with ALU_ARB_RR_EN the id sequence is 0,1,0,1; without it, 0,0,0.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* held stable and req_ready=00 throughout; one response only.
REQ-037 Illegal code: req1 alufn=000011 -> otp=0, zero=1, err=1, id=1.
REQ-038 Reset mid-EXEC: rst pulsed during EXEC -> no rsp_valid, IDLE next cycle, and the next request completes normally.
REQ-039 Subtract-to-zero: a=b=0x7 with alufn=000001 -> otp=0, zero=1, overflow=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU function codes, legal-code check and arbiter FSM state encoding.
package alu_pkg;

    localparam int unsigned ALUFN_W = 6;

    localparam logic [ALUFN_W-1:0] ALUFN_ADD  = 6'b000000;
    localparam logic [ALUFN_W-1:0] ALUFN_SUB  = 6'b000001;
    localparam logic [ALUFN_W-1:0] ALUFN_AND  = 6'b000010;
    localparam logic [ALUFN_W-1:0] ALUFN_OR   = 6'b000100;
    localparam logic [ALUFN_W-1:0] ALUFN_XOR  = 6'b000101;
    localparam logic [ALUFN_W-1:0] ALUFN_XNOR = 6'b000110;
    localparam logic [ALUFN_W-1:0] ALUFN_SHL  = 6'b001000;
    localparam logic [ALUFN_W-1:0] ALUFN_SHR  = 6'b001001;
    localparam logic [ALUFN_W-1:0] ALUFN_SRA  = 6'b001011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic alufn_legal(input logic [ALUFN_W-1:0] fn);
        logic ok;
        case (fn)
            ALUFN_ADD, ALUFN_SUB, ALUFN_AND, ALUFN_OR, ALUFN_XOR,
            ALUFN_XNOR, ALUFN_SHL, ALUFN_SHR, ALUFN_SRA: ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of the two-requester ALU arbiter.
interface alu_arbiter_if #(
    parameter int unsigned W = 32
);
    import alu_pkg::*;

    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0][W-1:0]          req_a;
    logic [1:0][W-1:0]          req_b;
    logic [1:0][ALUFN_W-1:0]    req_alufn;

    logic [W-1:0]               alu_a;
    logic [W-1:0]               alu_b;
    logic [ALUFN_W-1:0]         alu_alufn;
    logic [W-1:0]               alu_otp;
    logic                       alu_zero;
    logic                       alu_overflow;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic                       rsp_id;
    logic [W-1:0]               rsp_otp;
    logic                       rsp_zero;
    logic                       rsp_overflow;
    logic                       rsp_err;

    modport slave (
        input  req_valid, req_a, req_b, req_alufn,
        input  alu_otp, alu_zero, alu_overflow,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_alufn,
        output rsp_valid, rsp_id, rsp_otp, rsp_zero, rsp_overflow, rsp_err
    );

    modport master (
        output req_valid, req_a, req_b, req_alufn,
        output alu_otp, alu_zero, alu_overflow,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_alufn,
        input  rsp_valid, rsp_id, rsp_otp, rsp_zero, rsp_overflow, rsp_err
    );

endinterface

// File: rtl/alu_rr_grant.sv
// Two-input arbiter. ALU_ARB_RR_EN selects round-robin with a priority pointer;
// otherwise requester 0 always wins and no pointer exists.
module alu_rr_grant (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant_c
);

`ifdef ALU_ARB_RR_EN
    // Requester that wins the next tie; the one just granted drops behind.
    logic prio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (advance) begin
            prio_q <= ~grant_c[1];
        end
    end

    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = prio_q ? 2'b10 : 2'b01;
            default: grant_c = 2'b00;
        endcase
    end
`else
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, advance};

    always_comb begin
        grant_c = 2'b00;
        if (req[0]) begin
            grant_c = 2'b01;
        end else if (req[1]) begin
            grant_c = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: capture, one EXEC cycle, held response.
// Arbitration policy is set by ALU_ARB_RR_EN inside alu_rr_grant.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    state_t              state_q;
    state_t              state_d;

    logic [1:0]          grant_c;
    logic [1:0]          req_ready_c;
    logic                xfer_c;
    logic                grant_id_c;
    logic                rsp_load_c;
    logic                rsp_pop_c;

    logic [W-1:0]        cap_a_q;
    logic [W-1:0]        cap_b_q;
    logic [ALUFN_W-1:0]  cap_alufn_q;
    logic                cap_id_q;

    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [W-1:0]        rsp_otp_q;
    logic                rsp_zero_q;
    logic                rsp_overflow_q;
    logic                rsp_err_q;

    alu_rr_grant u_grant (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (xfer_c),
        .grant_c (grant_c)
    );

    assign xfer_c     = |(bus.req_valid & req_ready_c);
    assign grant_id_c = grant_c[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer_c) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = 2'b00;
        rsp_load_c  = 1'b0;
        rsp_pop_c   = 1'b0;
        case (state_q)
            IDLE:    req_ready_c = grant_c;
            EXEC:    rsp_load_c  = 1'b1;
            RESP:    rsp_pop_c   = bus.rsp_ready;
            default: req_ready_c = 2'b00;
        endcase
    end

    // Operands are latched at the transfer so the ALU never sees live request buses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_alufn_q <= '0;
            cap_id_q    <= 1'b0;
        end else if (xfer_c) begin
            cap_a_q     <= bus.req_a[grant_id_c];
            cap_b_q     <= bus.req_b[grant_id_c];
            cap_alufn_q <= bus.req_alufn[grant_id_c];
            cap_id_q    <= grant_id_c;
        end
    end

    // Illegal codes are answered with a fixed error result instead of the ALU output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_otp_q      <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_err_q      <= 1'b0;
        end else begin
            if (rsp_load_c) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= cap_id_q;
                if (alufn_legal(cap_alufn_q)) begin
                    rsp_otp_q      <= bus.alu_otp;
                    rsp_zero_q     <= bus.alu_zero;
                    rsp_overflow_q <= bus.alu_overflow;
                    rsp_err_q      <= 1'b0;
                end else begin
                    rsp_otp_q      <= '0;
                    rsp_zero_q     <= 1'b1;
                    rsp_overflow_q <= 1'b0;
                    rsp_err_q      <= 1'b1;
                end
            end else if (rsp_pop_c) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.alu_a        = cap_a_q;
    assign bus.alu_b        = cap_b_q;
    assign bus.alu_alufn    = cap_alufn_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_otp      = rsp_otp_q;
    assign bus.rsp_zero     = rsp_zero_q;
    assign bus.rsp_overflow = rsp_overflow_q;
    assign bus.rsp_err      = rsp_err_q;

endmodule
